jtag_scan_master: RTL and testbench

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

---
 rtl/jtag_pkg.sv | 60 ++++++
 rtl/jtag_tck_gen.sv | 37 +++
 rtl/jtag_scan_master.sv | 162 ++++++++++++++++
 tb/tb_jtag_scan_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// JTAG scan master shared types: TAP states, IR codes.
// TAP next-state helper used by the sequencer.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_state_e;

  localparam logic [3:0] IR_BYPASS    = 4'b1111;
  localparam logic [3:0] IR_SETPARAM  = 4'b0001;
  localparam logic [3:0] IR_RESET     = 4'b0010;
  localparam logic [3:0] IR_PAUSE     = 4'b0011;
  localparam logic [3:0] IR_RUN       = 4'b0100;
  localparam logic [3:0] IR_GETVAL    = 4'b0101;
  localparam logic [3:0] IR_TOGGLEDIR = 4'b0111;

  function automatic tap_state_e tap_next(
    input tap_state_e s,
    input logic       tms
  );
    tap_state_e n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: low half first, CLK_DIV clk cycles per half.
// rise/fall strobe the clk edge that drives tck high/low.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  logic [7:0] div;
  logic       wrap;

  assign wrap = run && (div == 8'(CLK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // half-period divider; parks tck low whenever not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      div <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: reset-to-idle, IR/DR scans via a tracked TAP.
// Define JTAG_SCAN_MASTER_TLR_EN to add the cmd_tlr reset command.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_MASTER_TLR_EN
  input  logic               cmd_tlr,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] P_INIT = 2'd0;
  localparam logic [1:0] P_IDLE = 2'd1;
  localparam logic [1:0] P_SCAN = 2'd2;

  logic [1:0]         phase;
  tap_state_e         state;
  logic [CW-1:0]      cnt;
  logic               is_ir;
  logic [5:0]         len_q;
  logic [5:0]         len_c;
  logic [5:0]         shamt;
  logic [MAX_LEN-1:0] sh;
  logic [MAX_LEN-1:0] cap;
  logic               run;
  logic               rise;
  logic               fall;
  logic               accept;
`ifdef JTAG_SCAN_MASTER_TLR_EN
  logic               tlr_q;
`endif

  assign run    = (phase != P_IDLE);
  assign accept = cmd_valid && cmd_ready;
  assign shamt  = 6'(MAX_LEN) - len_q;

  jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tck  (tck),
    .rise (rise),
    .fall (fall)
  );

  // clamp the requested length into 1..MAX_LEN
  always_comb begin
    len_c = cmd_len;
    if (cmd_len == 6'd0)
      len_c = 6'd1;
    else if (cmd_len > 6'(MAX_LEN))
      len_c = 6'(MAX_LEN);
  end

  // sequencer: TAP tracking on rise, tms/tdi updates on fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= P_INIT;
      state     <= TEST_LOGIC_RESET;
      cnt       <= '0;
      is_ir     <= 1'b0;
      len_q     <= 6'd1;
      sh        <= '0;
      cap       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b1;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef JTAG_SCAN_MASTER_TLR_EN
      tlr_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (rise) begin
        state <= tap_next(state, tms);
        if (state == SHIFT_DR || state == SHIFT_IR)
          cap <= {tdo, cap[MAX_LEN-1:1]};
      end
      if (phase == P_IDLE) begin
        if (accept) begin
          cmd_ready <= 1'b0;
          tms       <= 1'b1;
`ifdef JTAG_SCAN_MASTER_TLR_EN
          if (cmd_tlr) begin
            phase <= P_INIT;
            cnt   <= '0;
            tlr_q <= 1'b1;
          end else
`endif
          begin
            phase <= P_SCAN;
            is_ir <= cmd_is_ir;
            len_q <= len_c;
            cnt   <= CW'(len_c - 6'd1);
            sh    <= cmd_data;
          end
        end
      end else if (fall) begin
        if (phase == P_INIT) begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(4))
            tms <= 1'b0;
          if (cnt == CW'(5)) begin
            phase     <= P_IDLE;
            cmd_ready <= 1'b1;
            cnt       <= '0;
`ifdef JTAG_SCAN_MASTER_TLR_EN
            if (tlr_q) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              tlr_q     <= 1'b0;
            end
`endif
          end
        end else begin
          tdi <= 1'b1;
          case (state)
            RUN_TEST_IDLE: begin
              phase     <= P_IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_data  <= cap >> shamt;
            end
            SELECT_DR_SCAN: tms <= is_ir;
            SHIFT_DR, SHIFT_IR: begin
              tms <= (cnt == '0);
              tdi <= sh[0];
              sh  <= sh >> 1;
              if (cnt != '0)
                cnt <= cnt - CW'(1);
            end
            EXIT1_DR, EXIT1_IR,
            PAUSE_DR, PAUSE_IR,
            EXIT2_DR, EXIT2_IR: tms <= 1'b1;
            default: tms <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master against a small TAP target model.
// Directed scans with hand-computed expectations.
module tb_jtag_scan_master;
  import jtag_pkg::*;

  localparam int LIM = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_ir = 1'b0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = '0;
`ifdef JTAG_SCAN_MASTER_TLR_EN
  logic        cmd_tlr = 1'b0;
`endif
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int tck_cnt = 0;
  int rv_cnt = 0;
  int shift_n = 0;
  int last_rise = 0;
  int fall_cyc = 0;
  int period = 0;
  int hi_len = 0;
  logic [31:0] tms_log = '0;
  logic [31:0] tdi_log = '0;

  tap_state_e  ms = TEST_LOGIC_RESET;
  logic [3:0]  ir = 4'b1111;
  logic [3:0]  ir_sh = 4'b0000;
  logic [5:0]  dr_sh = 6'd0;
  logic [5:0]  param = 6'd0;

  jtag_scan_master #(
    .CLK_DIV(4),
    .MAX_LEN(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
`ifdef JTAG_SCAN_MASTER_TLR_EN
    .cmd_tlr  (cmd_tlr),
`endif
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rsp_valid) rv_cnt++;

  always @(posedge tck) begin
    period    = cyc - last_rise;
    last_rise = cyc;
    tck_cnt++;
    tms_log   = {tms_log[30:0], tms};
  end

  always @(negedge tck) begin
    hi_len   = cyc - last_rise;
    fall_cyc = cyc;
  end

  function automatic tap_state_e model_next(tap_state_e s, logic m);
    case (s)
      TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return m ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return m ? SELECT_IR_SCAN : CAPTURE_DR;
      SELECT_IR_SCAN:   return m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:  return m ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:  return m ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:  return m ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:  return m ? EXIT2_IR : PAUSE_IR;
      EXIT2_DR:  return m ? UPDATE_DR : SHIFT_DR;
      EXIT2_IR:  return m ? UPDATE_IR : SHIFT_IR;
      default:   return m ? SELECT_DR_SCAN : RUN_TEST_IDLE;
    endcase
  endfunction

  // target TAP: IR 4 bits capturing 0001, DR 6 bits capturing 2A
  always @(posedge tck) begin
    case (ms)
      TEST_LOGIC_RESET: ir <= IR_BYPASS;
      CAPTURE_IR: ir_sh <= 4'b0001;
      SHIFT_IR:   ir_sh <= {tdi, ir_sh[3:1]};
      UPDATE_IR:  ir <= ir_sh;
      CAPTURE_DR: dr_sh <= 6'h2A;
      SHIFT_DR: begin
        dr_sh   <= {tdi, dr_sh[5:1]};
        tdi_log <= {tdi, tdi_log[31:1]};
        shift_n <= shift_n + 1;
      end
      UPDATE_DR: if (ir == IR_SETPARAM) param <= dr_sh;
      default: ;
    endcase
    ms <= model_next(ms, tms);
  end

  always @(negedge tck) begin
    if (ms == SHIFT_IR)
      tdo <= ir_sh[0];
    else if (ms == SHIFT_DR)
      tdo <= dr_sh[0];
    else
      tdo <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_tck"}, 32'(tck), 32'd0);
    check({tag, "_tms"}, 32'(tms), 32'd1);
    check({tag, "_tdi"}, 32'(tdi), 32'd1);
    check({tag, "_rdy"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rd"}, rsp_data, 32'd0);
  endtask

  task automatic run_cmd(input logic ir_sel, input logic [5:0] len,
                         input logic [31:0] data,
                         output logic [31:0] rsp, output int tcks);
    int t0;
    int r0;
    wait_ready();
    t0 = tck_cnt;
    cmd_valid = 1'b1;
    cmd_is_ir = ir_sel;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    r0 = rv_cnt;
    @(negedge clk);
    check("rdy_drop", 32'(cmd_ready), 32'd0);
    wait_rsp();
    rsp  = rsp_data;
    tcks = tck_cnt - t0;
    check("rv_after_fall", 32'(cyc - fall_cyc), 32'd0);
    @(negedge clk);
    check("rv_pulse", 32'(rsp_valid), 32'd0);
    check("rv_cnt", 32'(rv_cnt - r0), 32'd1);
  endtask

  initial begin
    logic [31:0] rsp;
    int tcks;
    int t0;
    int r0;
    int s0;
    int n;

    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    t0 = tck_cnt;
    @(negedge clk);
    wait_ready();
    check("init_tcks", 32'(tck_cnt - t0), 32'd6);
    check("init_tms", {26'd0, tms_log[5:0]}, 32'b111110);
    check("init_period", 32'(period), 32'd8);
    check("init_high", 32'(hi_len), 32'd4);
    check("init_state", 32'(ms), 32'(RUN_TEST_IDLE));

    run_cmd(1'b1, 6'd4, 32'h5, rsp, tcks);
    check("ir_get_reg", 32'(ir), 32'(IR_GETVAL));
    check("ir_get_tcks", 32'(tcks), 32'd10);
    check("ir_get_rsp", rsp, 32'h1);

    run_cmd(1'b0, 6'd6, 32'h0, rsp, tcks);
    check("dr_cap_rsp", rsp, 32'h2A);
    check("dr_cap_tcks", 32'(tcks), 32'd11);

    run_cmd(1'b1, 6'd4, 32'(IR_SETPARAM), rsp, tcks);
    check("ir_set_reg", 32'(ir), 32'(IR_SETPARAM));
    run_cmd(1'b0, 6'd6, 32'h15, rsp, tcks);
    check("param_reg", 32'(param), 32'h15);
    check("tdi_order", {26'd0, tdi_log[31:26]}, 32'h15);
    check("dr_set_tcks", 32'(tcks), 32'd11);

    wait_ready();
    s0 = shift_n;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len   = 6'd6;
    cmd_data  = 32'h3F;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    r0 = rv_cnt;
    n = 0;
    while (shift_n < s0 + 3 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("mid_shift3", 32'(shift_n - s0), 32'd3);
    check("rsp_hold", rsp_data, 32'h2A);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outs("mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = tck_cnt;
    @(negedge clk);
    wait_ready();
    check("rerun_tcks", 32'(tck_cnt - t0), 32'd6);
    check("rerun_tms", {26'd0, tms_log[5:0]}, 32'b111110);
    check("abort_no_rv", 32'(rv_cnt - r0), 32'd0);
    check("rerun_state", 32'(ms), 32'(RUN_TEST_IDLE));

    t0 = tck_cnt;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len   = 6'd6;
    cmd_data  = 32'h15;
    @(posedge clk);
    #1;
    r0 = rv_cnt;
    wait_rsp();
    check("b2b_rdy", 32'(cmd_ready), 32'd1);
    check("b2b_rsp1", rsp_data, 32'h2A);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp();
    check("b2b_rsp2", rsp_data, 32'h2A);
    check("b2b_tcks", 32'(tck_cnt - t0), 32'd22);
    @(negedge clk);
    check("b2b_rv_cnt", 32'(rv_cnt - r0), 32'd2);

    run_cmd(1'b0, 6'd0, 32'hFFFF_FFFF, rsp, tcks);
    check("len0_tcks", 32'(tcks), 32'd6);
    check("len0_rsp", rsp, 32'h0);

    run_cmd(1'b0, 6'd40, 32'hDEAD_BEEF, rsp, tcks);
    check("len40_tcks", 32'(tcks), 32'd37);
    check("len40_rsp", rsp, (32'hDEAD_BEEF << 6) | 32'h2A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
